// File: rtl/pipe_stage_chain.sv
// Chain of pipeline interstage registers with per-stage valid, stall, flush,
// bubble collapsing and output backpressure.
module pipe_stage_chain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 4,
  localparam int unsigned OCC_W = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        stall_vec,
  input  logic [STAGES-1:0]        flush_vec,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic [OCC_W-1:0]         occupancy
);

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0]             hold;
  logic [STAGES-1:0]             src_valid;
  logic [STAGES-1:0][DATA_W-1:0] data_q, data_d, src_data;
  logic [OCC_W-1:0]              occ_q, occ_d;

  // Empty stages never hold for downstream pressure, so bubbles get squeezed out.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall_vec[STAGES-1] | (valid_q[STAGES-1] & ~out_ready);
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      hold[i] = stall_vec[i] | (valid_q[i] & hold[i+1]);
    end
  end

  always_comb begin
    src_valid    = '0;
    src_data     = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    for (int i = 1; i < int'(STAGES); i++) begin
      // A held upstream stage hands on a bubble, not a copy of its entry.
      src_valid[i] = valid_q[i-1] & ~hold[i-1];
      src_data[i]  = data_q[i-1];
    end

    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < int'(STAGES); i++) begin
      if (flush_vec[i]) begin
        valid_d[i] = 1'b0;
      end else if (!hold[i]) begin
        valid_d[i] = src_valid[i];
        if (src_valid[i]) begin
          data_d[i] = src_data[i];
        end
      end
    end

    occ_d = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign in_ready    = ~hold[0];
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = valid_q;
  assign stage_data  = data_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios plus randomized
// traffic against a slot-acceptance reference model; also a STAGES=1 instance.
module tb_pipe_stage_chain;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0]     in_data, out_data;
  logic [NS-1:0]     stall_vec, flush_vec, stage_valid;
  logic [NS*DW-1:0]  stage_data;
  logic [2:0]        occupancy;

  logic              s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0]        s_in_data, s_out_data, s_stage_data;
  logic [0:0]        s_stall, s_flush, s_stage_valid, s_occ;

  pipe_stage_chain #(.DATA_W(DW), .STAGES(NS)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_vec(stall_vec), .flush_vec(flush_vec), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .stage_valid(stage_valid),
    .stage_data(stage_data), .occupancy(occupancy)
  );

  pipe_stage_chain #(.DATA_W(8), .STAGES(1)) u_one (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .stall_vec(s_stall), .flush_vec(s_flush),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .stage_valid(s_stage_valid), .stage_data(s_stage_data), .occupancy(s_occ)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one optional entry per slot.
  bit          m_v[NS];
  bit [DW-1:0] m_d[NS];
  bit          exp_rdy, got_rdy, fire;
  logic [DW-1:0] outs[$];

  // A slot accepts if it is not stalled and is empty or its occupant departs.
  function automatic void model_step();
    bit          acc[NS+1];
    bit          nv[NS];
    bit [DW-1:0] nd[NS];
    bit          sv;
    bit [DW-1:0] sd;
    acc[NS] = out_ready;
    for (int i = NS - 1; i >= 0; i--) acc[i] = !stall_vec[i] && (!m_v[i] || acc[i+1]);
    exp_rdy = acc[0];
    for (int i = 0; i < NS; i++) begin
      nv[i] = m_v[i];
      nd[i] = m_d[i];
      if (i == 0) begin
        sv = in_valid;
        sd = in_data;
      end else begin
        sv = m_v[i-1] && !stall_vec[i-1];
        sd = m_d[i-1];
      end
      if (flush_vec[i]) nv[i] = 1'b0;
      else if (acc[i]) begin
        nv[i] = sv;
        if (sv) nd[i] = sd;
      end
    end
    for (int i = 0; i < NS; i++) begin
      m_v[i] = rst ? 1'b0 : nv[i];
      m_d[i] = rst ? '0 : nd[i];
    end
  endfunction

  function automatic logic [NS-1:0] model_valid();
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = m_v[i];
    return r;
  endfunction

  function automatic logic [NS*DW-1:0] model_data();
    logic [NS*DW-1:0] r;
    for (int i = 0; i < NS; i++) r[i*DW +: DW] = m_d[i];
    return r;
  endfunction

  function automatic logic [2:0] model_occ();
    logic [2:0] r = '0;
    for (int i = 0; i < NS; i++) r = r + 3'(m_v[i]);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [NS-1:0] st,
                       input logic [NS-1:0] fl, input logic ordy, input logic r);
    in_valid  = v;
    in_data   = d;
    stall_vec = st;
    flush_vec = fl;
    out_ready = ordy;
    rst       = r;
  endtask

  // Sample pre-edge handshakes, advance model and DUT one edge, return at negedge.
  task automatic tick();
    #1;
    got_rdy = in_ready;
    fire    = out_valid & out_ready;
    if (fire) outs.push_back(out_data);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    outs.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (stage_valid !== 4'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b want 0", stage_valid); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++;
      $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_fail++;
      $display("FAIL reset_out: got %b/%h want 0/0", out_valid, out_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    logic       ev;
    logic [2:0] max_occ = '0;
    do_reset();
    for (int t = 1; t <= 10; t++) begin
      drive(t <= 5, (t <= 5) ? 32'h11 * t : 32'h0, '0, '0, 1'b1, 1'b0);
      tick();
      ev = (t >= 4 && t <= 8);
      n_checks++; if (got_rdy !== 1'b1) begin n_fail++;
        $display("FAIL stream_in_ready t=%0d: got %b want 1", t, got_rdy); end
      n_checks++; if (out_valid !== ev) begin n_fail++;
        $display("FAIL stream_out_valid t=%0d: got %b want %b", t, out_valid, ev); end
      if (occupancy > max_occ) max_occ = occupancy;
    end
    n_checks++; if (max_occ !== 3'd4) begin n_fail++;
      $display("FAIL stream_max_occ: got %0d want 4", max_occ); end
    n_checks++; if (outs.size() != 5) begin n_fail++;
      $display("FAIL stream_count: got %0d want 5", outs.size()); end
    for (int i = 0; i < 5 && i < outs.size(); i++) begin
      n_checks++; if (outs[i] !== 32'h11 * (i + 1)) begin n_fail++;
        $display("FAIL stream_data[%0d]: got %h want %h", i, outs[i], 32'h11 * (i + 1)); end
    end
  endtask

  task automatic test_backpressure();
    bit          vv[5] = '{1, 0, 1, 1, 1};
    bit [DW-1:0] dd[5] = '{32'hA0, 32'h0, 32'hA1, 32'hA2, 32'hA3};
    do_reset();
    for (int t = 0; t < 5; t++) begin
      drive(vv[t], dd[t], '0, '0, 1'b0, 1'b0);
      tick();
      n_checks++; if (got_rdy !== 1'b1) begin n_fail++;
        $display("FAIL bp_fill_ready t=%0d: got %b want 1", t, got_rdy); end
      if (t == 3) begin
        n_checks++; if (stage_valid !== 4'b1011 || occupancy !== 3'd3) begin n_fail++;
          $display("FAIL bp_bubble: got %b/%0d want 1011/3", stage_valid, occupancy); end
      end
    end
    n_checks++; if (stage_valid !== 4'b1111 || occupancy !== 3'd4) begin n_fail++;
      $display("FAIL bp_collapse: got %b/%0d want 1111/4", stage_valid, occupancy); end
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 32'hEE, '0, '0, 1'b0, 1'b0);
      tick();
      n_checks++; if (got_rdy !== 1'b0) begin n_fail++;
        $display("FAIL bp_full_ready: got %b want 0", got_rdy); end
      n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hA0) begin n_fail++;
        $display("FAIL bp_stable: got %b/%h want 1/a0", out_valid, out_data); end
    end
    for (int t = 0; t < 8; t++) begin
      drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
      tick();
    end
    n_checks++; if (outs.size() != 4) begin n_fail++;
      $display("FAIL bp_count: got %0d want 4", outs.size()); end
    for (int i = 0; i < 4 && i < outs.size(); i++) begin
      n_checks++; if (outs[i] !== 32'hA0 + i) begin n_fail++;
        $display("FAIL bp_data[%0d]: got %h want %h", i, outs[i], 32'hA0 + i); end
    end
  endtask

  task automatic test_mid_stall();
    int k = 0, first = -1, last = -1;
    do_reset();
    for (int c = 0; c < 40 && outs.size() < 10; c++) begin
      drive(k < 10, 32'hC0 + k, (c == 5 || c == 6) ? 4'b0010 : 4'b0000, '0, 1'b1, 1'b0);
      tick();
      if (c == 5 || c == 6) begin
        n_checks++; if (got_rdy !== 1'b0) begin n_fail++;
          $display("FAIL stall_in_ready c=%0d: got %b want 0", c, got_rdy); end
      end
      if (got_rdy && k < 10) k++;
      if (fire) begin
        if (first < 0) first = c;
        last = c;
      end
    end
    n_checks++; if (outs.size() != 10) begin n_fail++;
      $display("FAIL stall_count: got %0d want 10", outs.size()); end
    n_checks++; if ((last - first + 1) - outs.size() != 2) begin n_fail++;
      $display("FAIL stall_bubbles: got %0d want 2", (last - first + 1) - outs.size()); end
    for (int i = 0; i < outs.size(); i++) begin
      n_checks++; if (outs[i] !== 32'hC0 + i) begin n_fail++;
        $display("FAIL stall_data[%0d]: got %h want %h", i, outs[i], 32'hC0 + i); end
    end
  endtask

  task automatic test_flush();
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      drive(1'b1, 32'hB1, '0, '0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'hB0, '0, '0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'hB2, (rep == 1) ? 4'b0010 : 4'b0000, 4'b0011, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
      if (rep == 0) begin
        n_checks++; if (stage_valid !== 4'b0100 || stage_data[2*DW +: DW] !== 32'hB1)
        begin n_fail++;
          $display("FAIL flush_keep: got %b/%h want 0100/b1", stage_valid,
                   stage_data[2*DW +: DW]); end
        n_checks++; if (occupancy !== 3'd1) begin n_fail++;
          $display("FAIL flush_occ: got %0d want 1", occupancy); end
      end else begin
        n_checks++; if (stage_valid !== 4'b0000 || occupancy !== 3'd0) begin n_fail++;
          $display("FAIL flush_stalled: got %b/%0d want 0000/0", stage_valid, occupancy); end
      end
      for (int t = 0; t < 5; t++) tick();
      n_checks++; if (outs.size() != 1 - rep || (rep == 0 && outs[0] !== 32'hB1)) begin
        n_fail++;
        $display("FAIL flush_out rep=%0d: got %0d entries want %0d", rep, outs.size(), 1 - rep);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 32'hD0 + t, '0, '0, 1'b1, 1'b0);
      tick();
    end
    n_checks++; if (occupancy !== 3'd3) begin n_fail++;
      $display("FAIL rstmid_pre_occ: got %0d want 3", occupancy); end
    drive(1'b1, 32'hDD, '0, '0, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    #1;
    n_checks++; if (stage_valid !== 4'b0 || occupancy !== 3'd0 || out_data !== 32'h0
                    || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_state: got %b/%0d/%h want 0/0/0", stage_valid, occupancy, out_data);
    end
    outs.delete();
    for (int t = 0; t < 5; t++) tick();
    n_checks++; if (outs.size() != 0) begin n_fail++;
      $display("FAIL rstmid_spurious: got %0d outputs want 0", outs.size()); end
  endtask

  task automatic test_random();
    logic [NS-1:0] st, fl;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NS; i++) begin
        st[i] = ($urandom_range(0, 7) == 0);
        fl[i] = ($urandom_range(0, 15) == 0);
      end
      drive($urandom_range(0, 1) == 1, $urandom, st, fl, $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0);
      tick();
      n_checks++; if (got_rdy !== exp_rdy) begin n_fail++;
        $display("FAIL rand_in_ready c=%0d: got %b want %b", c, got_rdy, exp_rdy); end
      n_checks++; if (stage_valid !== model_valid()) begin n_fail++;
        $display("FAIL rand_valid c=%0d: got %b want %b", c, stage_valid, model_valid()); end
      n_checks++; if (stage_data !== model_data()) begin n_fail++;
        $display("FAIL rand_data c=%0d: got %h want %h", c, stage_data, model_data()); end
      n_checks++; if (occupancy !== model_occ()) begin n_fail++;
        $display("FAIL rand_occ c=%0d: got %0d want %0d", c, occupancy, model_occ()); end
      n_checks++; if (out_valid !== m_v[NS-1] || out_data !== m_d[NS-1]) begin n_fail++;
        $display("FAIL rand_out c=%0d: got %b/%h want %b/%h", c, out_valid, out_data,
                 m_v[NS-1], m_d[NS-1]); end
    end
    do_reset();
  endtask

  task automatic test_single_stage();
    logic [7:0] exp_next = 8'h30;
    int         xfers    = 0;
    logic       acc;
    s_rst       = 1'b0;
    s_in_data   = 8'h30;
    for (int c = 0; c < 20; c++) begin
      s_out_ready = c[0];
      s_in_valid  = 1'b1;
      #1;
      if (s_out_valid) begin
        n_checks++; if (s_in_ready !== s_out_ready) begin n_fail++;
          $display("FAIL one_ready c=%0d: got %b want %b", c, s_in_ready, s_out_ready); end
      end
      if (s_out_valid && s_out_ready) begin
        n_checks++; if (s_out_data !== exp_next) begin n_fail++;
          $display("FAIL one_data c=%0d: got %h want %h", c, s_out_data, exp_next); end
        exp_next++;
        xfers++;
      end
      acc = s_in_ready;
      tick();
      if (acc) s_in_data++;
    end
    n_checks++; if (xfers != 10) begin n_fail++;
      $display("FAIL one_xfers: got %0d want 10", xfers); end
  endtask

  initial begin
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    s_stall = '0; s_flush = '0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_mid_stall();
    test_flush();
    test_reset_mid();
    test_random();
    test_single_stage();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of pipeline interstage registers with per-stage valid bits, stall, flush, bubble collapsing and output backpressure.
- Generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers, which have hard-coded fields, a single write-enable and an async flush, into one reusable block.
- Intended for the next datapath generation and for multicycle functional units such as mul/div.

Parameters:
- DATA_W, 32, payload width per stage in bits.
- STAGES, 4, number of register stages, minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  payload at in_data is valid this cycle.
- in_data  in  DATA_W  stage-0 input payload.
- in_ready  out  1  stage 0 can accept this cycle; a transfer occurs when in_valid & in_ready.
- stall_vec  in  STAGES  bit i forces stage i to hold its contents.
- flush_vec  in  STAGES  bit i invalidates stage i at the next edge.
- out_valid  out  1  equals valid[STAGES-1].
- out_data  out  DATA_W  equals data[STAGES-1].
- out_ready  in  1  consumer accepts out_data this cycle.
- stage_valid  out  STAGES  valid bit of every stage, for hazard/forwarding logic.
- stage_data  out  STAGES*DATA_W  payload of every stage; stage i occupies bits [i*DATA_W +: DATA_W].
- occupancy  out  clog2(STAGES+1)  count of valid stages, registered.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - All valid bits, all data registers and occupancy go to 0.
  - Outputs after reset: in_ready=1 (if stall_vec=0), out_valid=0, out_data=0.
  - Reset overrides every other input. Reset asserted mid-stream discards all in-flight entries, with no partial output.
- Hold chain (combinational, evaluated from the last stage down to stage 0):
  - hold[STAGES-1] = stall_vec[STAGES-1] | (valid[STAGES-1] & ~out_ready).
  - hold[i] = stall_vec[i] | (valid[i] & hold[i+1]) for i < STAGES-1.
  - Consequence: an empty stage never holds because of downstream pressure, so bubbles collapse.
- in_ready = ~hold[0]. No combinational path from in_valid to in_ready.
- Per-stage next state, with priority rst > flush > hold > load:
  - flush_vec[i]=1: valid[i] <= 0; data[i] holds.
  - Else if hold[i]=1: valid[i] and data[i] hold.
  - Else load from the upstream source, which is in_valid/in_data for stage 0 and stage i-1 for stage i>0:
    - Upstream valid is taken as src_valid & ~hold[src] for i>0, and in_valid for stage 0.
    - valid[i] <= upstream valid.
    - data[i] <= src_data only when upstream valid=1; otherwise data[i] holds.
- Bubble insertion: if stage i holds and stage i+1 does not, stage i+1 receives valid=0 at the next edge.
  - Multiple stalled stages each insert their own bubble independently.
- Flush interactions:
  - Flush of a held stage clears it. Upstream stages still see hold[i] evaluated with the pre-flush valid, so there is no same-cycle combinational loop through flush.
  - flush_vec[0] together with an in_valid & in_ready transfer drops the incoming entry.
  - Flush of stage i does not affect stage i+1 loading from stage i in the same cycle, because the entry moves on before the clear.
- Latency and throughput:
  - With no stalls, no flushes and out_ready=1, an entry accepted at edge N appears at out_data after edge N+STAGES-1.
  - Throughput is one entry per cycle.
- Output transfer occurs when out_valid & out_ready. out_data is stable while out_valid=1 and out_ready=0.
- occupancy is the registered popcount of next-state valid bits, updated each edge, and never exceeds STAGES.
- STAGES=1: the block degenerates to a single register with stall, flush and backpressure, and in_ready = ~(stall | (valid & ~out_ready)).

Test Plan (DATA_W=32, STAGES=4 unless noted):
- Streaming: after rst, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles with out_ready=1 and stall/flush=0. Required: out_valid rises 3 edges after the first accept, outputs appear in order on consecutive cycles, occupancy reaches 4, in_ready stays 1 throughout.
- Backpressure with collapse: fill the pipe with 0xA0..0xA3, then hold out_ready=0.
  - Required: out_data stays 0xA0; in_ready=0 only once all 4 stages are valid.
  - A bubble at stage 2 must be filled while out_ready=0, which requires occupancy to rise from 3 to 4.
- Mid stall: with a full stream, pulse stall_vec=4'b0010 for 2 cycles.
  - Required: stages 0–1 hold and in_ready=0.
  - Stage 2 gets valid=0 for 2 cycles, giving exactly 2 bubbles at the output; no data is lost or duplicated.
- Flush: with stages 0–1 holding 0xB0,0xB1, assert flush_vec=4'b0011 for one cycle while in_valid=1 with 0xB2.
  - Required: 0xB0 and 0xB2 are dropped and 0xB1 continues (it moved to stage 2 that edge); occupancy drops accordingly.
  - Repeat with stall_vec[1]=1: 0xB1 is dropped.
- Reset mid-operation: with 3 entries in flight, assert rst for 1 cycle together with in_valid=1.
  - Required: next cycle stage_valid=0, occupancy=0, out_data=0, and no spurious output.
- STAGES=1, DATA_W=8: alternate out_ready=0/1 every cycle under continuous input.
  - Required: exactly one transfer per two cycles, and in_ready equals out_ready whenever valid=1.
